fp2_addsub_pipe: RTL
====================

FP2_ADDSUB_PIPE -- requirements
Module: fp2_addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 255: bit width of each Fp coordinate.
REQ-002 SHALL have parameter P, default sqisign_pkg::P_LVL1 (5*2^248-1): field modulus, P < 2^WIDTH.
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each operation.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: the operand set is valid.
REQ-007 SHALL have port in_ready, output, 1: the block accepts the operand set this cycle.
REQ-008 SHALL have port op, input, 1: operation select; 0 = D = A+B, 1 = D = A-B.
REQ-009 SHALL have ports a_re, a_im, b_re, b_im, input, WIDTH each: A = a_re + i*a_im and B = b_re + i*b_im.
REQ-010 SHALL have port in_tag, input, TAG_W: opaque sideband, returned unchanged with the result.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have ports d_re, d_im, output, WIDTH each: result coordinates, fully reduced into [0, P).
REQ-014 SHALL have port out_tag, output, TAG_W: in_tag of the same operation.

Function
REQ-015 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-016 SHALL compute d_re = (a_re op b_re) mod P and d_im = (a_im op b_im) mod P, provided all inputs are < P; behaviour for inputs >= P is outside the contract.
REQ-017 SHALL use a 3-stage pipeline: S1 registers the operands, op and tag; S2 forms a WIDTH+1-bit raw sum or a borrow-extended difference; S3 applies the correction.
REQ-018 S3 correction SHALL be: for add, subtract P when raw >= P; for sub, add P when the borrow is set; otherwise pass raw unchanged.
REQ-019 Latency SHALL be exactly 3 cycles from an input handshake to out_valid, in the absence of stall.
REQ-020 SHALL sustain throughput of 1 operation per cycle when out_ready is held at 1.
REQ-021 SHALL stall globally: when out_valid && !out_ready, no stage register or valid bit changes, and in_ready = 0.
REQ-022 in_ready SHALL equal !(out_valid && !out_ready), a combinational function of registered state and out_ready only, with no path from in_valid.
REQ-023 Empty stages (bubbles) SHALL carry valid = 0 and SHALL still advance while not stalled.
REQ-024 d_re, d_im and out_tag SHALL hold stable while out_valid && !out_ready.
REQ-025 Results SHALL leave in acceptance order; operations SHALL NOT be dropped or duplicated.
REQ-026 Consecutive operations SHALL be allowed to alternate op freely; op SHALL travel with its own data.

Reset
REQ-027 Assertion of rst_n = 0 SHALL immediately clear all stage valid bits, making out_valid = 0 and in_ready = 1, even mid-operation; in-flight operations are discarded.
REQ-028 During reset d_re, d_im and out_tag SHALL read 0; data registers SHALL be reset to 0.
REQ-029 The first input handshake SHALL be possible in the first rising edge after rst_n deasserts.

Structure
REQ-030 Package sqisign_pkg SHALL hold P_LVL1, the default WIDTH, and localparam LATENCY_FP2_ADDSUB = 3.
REQ-031 SHALL instantiate sub-module fp_addsub_stage twice, once per coordinate. This sub-module is a 2-stage raw/correct Fp add/sub with a stall enable, and is parametrised by WIDTH and P.
REQ-032 Valid bits, tag, op pipeline and stall logic SHALL reside in fp2_addsub_pipe only.

Verification
REQ-033 Add wrap: op=0, a_re=P-1, b_re=1, a_im=2, b_im=3 -> after 3 cycles d_re=0, d_im=5.
REQ-034 Sub borrow: op=1, a_re=0, b_re=1, a_im=7, b_im=7 -> d_re=P-1, d_im=0.
REQ-035 Streaming: 1000 random reduced operands, mixed op, out_ready=1, tags 0..15 cycling -> 1000 consecutive out_valid cycles after a 3-cycle fill, all matching the reference model and in order.
REQ-036 Backpressure: out_ready=0 for 5 cycles with the pipe full -> in_ready=0 and outputs stable throughout; on release 3 results drain in order with none lost.
REQ-037 Reset mid-flight: 2 operations accepted, rst_n pulsed low asynchronously between edges -> out_valid=0 at once; no stale result appears after release.
REQ-038 Parametrisation: WIDTH=8, P=251, exhaustive a,b in [0,251) for both ops -> all results equal (a±b) mod 251.

Source files
------------

// File: rtl/sqisign_pkg.sv
// Shared constants and types for the SQIsign level-1 field arithmetic blocks.
package sqisign_pkg;
  localparam int FP_WIDTH = 255;
  localparam logic [FP_WIDTH-1:0] P_LVL1 = (255'd5 << 248) - 255'd1;
  localparam int LATENCY_FP2_ADDSUB = 3;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } fp_op_e;
endpackage

// File: rtl/fp_addsub_stage.sv
// Two-stage Fp add/sub: a raw WIDTH+1-bit sum/difference, then a single
// conditional +/-P correction. Both stages freeze when en is low.
module fp_addsub_stage
  import sqisign_pkg::*;
#(
  parameter int               WIDTH = FP_WIDTH,
  parameter logic [WIDTH-1:0] P     = WIDTH'(P_LVL1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             raw_op,
  input  logic             corr_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d
);
  logic [WIDTH:0]   raw_q, raw_d;
  logic [WIDTH-1:0] res_q, res_d;

  always_comb begin
    raw_d = raw_q;
    res_d = res_q;
    if (en) begin
      // For subtraction the top bit of raw is the borrow out of a-b.
      raw_d = (raw_op == OP_SUB) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      if (corr_op == OP_SUB) begin
        res_d = raw_q[WIDTH] ? (raw_q[WIDTH-1:0] + P) : raw_q[WIDTH-1:0];
      end else begin
        res_d = (raw_q >= {1'b0, P}) ? WIDTH'(raw_q - {1'b0, P}) : raw_q[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= '0;
      res_q <= '0;
    end else begin
      raw_q <= raw_d;
      res_q <= res_d;
    end
  end

  assign d = res_q;
endmodule

// File: rtl/fp2_addsub_pipe.sv
// Fp2 add/sub, 3-stage pipeline with valid/ready handshake and global stall.
// Owns valid bits, op/tag pipelines and stall control; arithmetic is per coordinate.
module fp2_addsub_pipe
  import sqisign_pkg::*;
#(
  parameter int               WIDTH = FP_WIDTH,
  parameter logic [WIDTH-1:0] P     = WIDTH'(P_LVL1),
  parameter int               TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_re,
  output logic [WIDTH-1:0] d_im,
  output logic [TAG_W-1:0] out_tag
);
  localparam int LAT = LATENCY_FP2_ADDSUB;

  logic [LAT-1:0]            valid_q, valid_d;
  logic [1:0]                op_q, op_d;
  logic [LAT-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0]          a_re_q, a_re_d, a_im_q, a_im_d;
  logic [WIDTH-1:0]          b_re_q, b_re_d, b_im_q, b_im_d;
  logic                      advance;

  // Stall depends only on registered state and out_ready, never on in_valid.
  assign advance   = !(valid_q[LAT-1] && !out_ready);
  assign in_ready  = advance;
  assign out_valid = valid_q[LAT-1];
  assign out_tag   = tag_q[LAT-1];

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    tag_d   = tag_q;
    a_re_d  = a_re_q;
    a_im_d  = a_im_q;
    b_re_d  = b_re_q;
    b_im_d  = b_im_q;
    if (advance) begin
      valid_d = {valid_q[LAT-2:0], in_valid};
      op_d    = {op_q[0], op};
      tag_d   = {tag_q[LAT-2:0], in_tag};
      // Operands only toggle on real transfers; bubbles reuse the old values.
      if (in_valid) begin
        a_re_d = a_re;
        a_im_d = a_im;
        b_re_d = b_re;
        b_im_d = b_im;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      a_re_q  <= '0;
      a_im_q  <= '0;
      b_re_q  <= '0;
      b_im_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      a_re_q  <= a_re_d;
      a_im_q  <= a_im_d;
      b_re_q  <= b_re_d;
      b_im_q  <= b_im_d;
    end
  end

  fp_addsub_stage #(.WIDTH(WIDTH), .P(P)) u_re (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (advance),
    .raw_op (op_q[0]),
    .corr_op(op_q[1]),
    .a      (a_re_q),
    .b      (b_re_q),
    .d      (d_re)
  );

  fp_addsub_stage #(.WIDTH(WIDTH), .P(P)) u_im (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (advance),
    .raw_op (op_q[0]),
    .corr_op(op_q[1]),
    .a      (a_im_q),
    .b      (b_im_q),
    .d      (d_im)
  );
endmodule
